score_display_ctrl: RTL and testbench
=====================================

Name: score_display_ctrl

Overview:
- Game-side score controller: arbitrates point-award requests from two requesters (player A / player B logic) onto one shared 10-bit score register.
- Sequences a multi-cycle binary-to-BCD conversion (shift-add-3, one bit per cycle).
- Drives the registered three-digit active-low 7-segment bus to the board display.
- Replaces free-running combinational modulo decode with a scheduled, handshaked update path.

Parameters:
- MAX_SCORE, 999, saturation ceiling for score; must be <= 999.
- SCORE_W, 10, score width; also the conversion iteration count.
- PTS_W, 4, width of each requester's points field.

Ports:
- clock  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_a_valid  in  1  requester A has points to award.
- req_a_pts  in  PTS_W  points from A; held stable while valid and not ready.
- req_a_ready  out  1  A's request accepted this cycle.
- req_b_valid  in  1  requester B has points to award.
- req_b_pts  in  PTS_W  points from B.
- req_b_ready  out  1  B's request accepted this cycle.
- clr  in  1  level request to zero the score.
- score  out  SCORE_W  current binary score (registered).
- seg_out  out  21  active-low segments: [6:0] ones, [13:7] tens, [20:14] hundreds; bit order gfedcba.
- busy  out  1  high while a conversion is running.
- disp_valid  out  1  one-cycle pulse when seg_out has just been updated.

Behaviour:
- Reset (resetn low, async):
  - score=0; seg_out={3{7'b1000000}} ("000"); busy=0; disp_valid=0.
  - Both ready=0; state=IDLE; clr_pend=0; last_grant=B, so A wins the first tie.
- FSM states: IDLE, CONV.
- IDLE:
  - If clr or clr_pend: score<=0, clr_pend<=0, no ready asserted, go CONV.
  - Else if any valid: grant one requester; its ready=1 combinationally this cycle; go CONV.
    - If both valid: grant the one not equal to last_grant; last_grant<=winner.
    - Score update: score<=min(score+pts, MAX_SCORE). Sum is computed at SCORE_W+1 bits, so no wrap.
  - ready is never asserted outside IDLE; the loser's valid is held and served later.
- CONV:
  - busy=1. Runs a 4-bit iteration counter 0..SCORE_W-1 on a shift-add-3 register loaded from the new score.
  - Each cycle: add 3 to any BCD nibble >=5, then shift left one bit.
  - After iteration SCORE_W-1:
    - Decode each nibble to 7 segments. Table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
    - Register seg_out, pulse disp_valid for 1 cycle, return to IDLE.
- Latency: accept/clear edge E -> seg_out and disp_valid update at edge E+SCORE_W (10 cycles). The next request may be accepted in the cycle disp_valid is high.
- clr during CONV: sets clr_pend; serviced in the first IDLE cycle, ahead of any pending requests.
- clr and valid together in IDLE: clr wins; no ready asserted; the request stays pending.
- pts=0: accepted normally; conversion still runs; disp_valid still pulses.
- Already at MAX_SCORE: further awards are accepted; score is held at MAX_SCORE.
- resetn asserted mid-CONV: conversion aborts; all outputs return to reset values immediately.
- seg_out holds its previous value throughout CONV; it never shows partial results.

Optional Feature:
- LEADING_ZERO_BLANK_EN, defined:
  - Hundreds digit shows 7'b1111111 when the hundreds nibble is 0.
  - Tens digit is blanked when both hundreds and tens are 0.
  - Ones digit is always shown.
  - Reset seg_out becomes {7'b1111111,7'b1111111,7'b1000000}.
- Not defined: all three digits are always displayed, including leading zeros.

Test Plan:
- Reset -> score=0, seg_out=21'b1000000_1000000_1000000, busy=0, disp_valid=0, both ready=0.
- A valid, pts=5, from reset -> req_a_ready=1 for one cycle; score=5; busy for 10 cycles; then disp_valid pulse with seg_out[6:0]=0010010 and upper digits showing 0.
- A and B valid same cycle (pts 3 and 7) -> A granted first (score=3, disp "003"), then B (score=10, disp "010"). A third tie grants B first.
- score=995, A pts=9 -> score=999; seg_out=0010000 in all three digits.
- clr pulsed 4 cycles into a conversion, with B valid -> current conversion finishes first. Then the clear is served: score=0, display "000". Then B is granted.
- With LEADING_ZERO_BLANK_EN, score=42 -> seg_out[20:14]=1111111, [13:7]=0011001, [6:0]=0100100.

Source files
------------

// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
//
// Game-side score controller. Two requesters (player A / player B) offer point
// awards through valid/ready handshakes; a single winner per idle cycle is
// added into a saturating binary score register. Each accepted award (or
// clear) kicks off a shift-add-3 binary-to-BCD conversion, one bit per cycle.
// When it completes, the three BCD digits are decoded onto a registered,
// active-low 7-segment bus and disp_valid pulses for one cycle.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank leading zero digits (hundreds, then tens);
//                           the ones digit is always lit.
//
// Ports:
//   clock        in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   req_a_valid  in   requester A has points to award
//   req_a_pts    in   A's points (stable while valid && !ready)
//   req_a_ready  out  A's request accepted this cycle (combinational)
//   req_b_valid  in   requester B has points to award
//   req_b_pts    in   B's points
//   req_b_ready  out  B's request accepted this cycle (combinational)
//   clr          in   level request to zero the score
//   score        out  current binary score (registered)
//   seg_out      out  active-low segments, gfedcba per digit:
//                     [6:0] ones, [13:7] tens, [20:14] hundreds
//   busy         out  conversion in progress
//   disp_valid   out  one-cycle pulse after seg_out is updated
// -----------------------------------------------------------------------------
module score_display_ctrl #(
  parameter int MAX_SCORE = 999,  // saturation ceiling, must be <= 999
  parameter int SCORE_W   = 10,   // score width and conversion iteration count
  parameter int PTS_W     = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               req_a_valid,
  input  logic [PTS_W-1:0]   req_a_pts,
  output logic               req_a_ready,
  input  logic               req_b_valid,
  input  logic [PTS_W-1:0]   req_b_pts,
  output logic               req_b_ready,
  input  logic               clr,
  output logic [SCORE_W-1:0] score,
  output logic [20:0]        seg_out,
  output logic               busy,
  output logic               disp_valid
);

  localparam int BCD_W = 12;               // three BCD nibbles
  localparam int SR_W  = SCORE_W + BCD_W;  // shift-add-3 working register
  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(MAX_SCORE);
  localparam logic [3:0]       LAST_IT = 4'(SCORE_W - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [20:0] SEG_RST = {SEG_BLANK, SEG_BLANK, SEG_ZERO};
`else
  localparam logic [20:0] SEG_RST = {SEG_ZERO, SEG_ZERO, SEG_ZERO};
`endif

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [SR_W-1:0]    sr_reg, sr_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic               clr_pend_reg, clr_pend_next;
  logic               last_grant_reg, last_grant_next;  // 1 = B was last tie winner
  logic [20:0]        seg_reg, seg_next;
  logic               disp_valid_reg, disp_valid_next;

  logic               grant_a, grant_b;
  logic [PTS_W-1:0]   pts_sel;
  logic [SCORE_W:0]   sum;

  logic [SR_W-1:0]    sr_adj;   // after add-3 correction
  logic [SR_W-1:0]    sr_step;  // after correction and shift
  logic [3:0]         bcd_dig [3];
  logic [6:0]         seg_dig [3];
  logic [20:0]        seg_new;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;  // unreachable for scores <= 999
    endcase
    return s;
  endfunction

  // One shift-add-3 iteration: correct every BCD nibble that would overflow
  // past 9 when doubled, then shift the whole register left by one.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = sr_reg[SCORE_W + 4*gi +: 4];
      assign sr_adj[SCORE_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign sr_adj[SCORE_W-1:0] = sr_reg[SCORE_W-1:0];
  assign sr_step = {sr_adj[SR_W-2:0], 1'b0};

  // Digits are decoded from the result of the final iteration so seg_out can
  // be registered on the same edge that completes the conversion.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dec
      assign bcd_dig[gi] = sr_step[SCORE_W + 4*gi +: 4];
      assign seg_dig[gi] = seg7(bcd_dig[gi]);
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  assign seg_new = {(bcd_dig[2] == 4'd0) ? SEG_BLANK : seg_dig[2],
                    ((bcd_dig[2] == 4'd0) && (bcd_dig[1] == 4'd0)) ? SEG_BLANK : seg_dig[1],
                    seg_dig[0]};
`else
  assign seg_new = {seg_dig[2], seg_dig[1], seg_dig[0]};
`endif

  always_comb begin
    state_next      = state_reg;
    score_next      = score_reg;
    sr_next         = sr_reg;
    cnt_next        = cnt_reg;
    clr_pend_next   = clr_pend_reg;
    last_grant_next = last_grant_reg;
    seg_next        = seg_reg;
    disp_valid_next = 1'b0;
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    pts_sel         = '0;
    sum             = '0;

    case (state_reg)
      IDLE: begin
        if (clr || clr_pend_reg) begin
          // Clear outranks any pending award; requests stay pending.
          score_next    = '0;
          clr_pend_next = 1'b0;
          sr_next       = '0;
          cnt_next      = '0;
          state_next    = CONV;
        end else if (req_a_valid || req_b_valid) begin
          if (req_a_valid && req_b_valid) begin
            // Tie: alternate against the previous tie winner only.
            grant_a         = last_grant_reg;
            grant_b         = !last_grant_reg;
            last_grant_next = !last_grant_reg;
          end else begin
            grant_a = req_a_valid;
            grant_b = req_b_valid;
          end
          pts_sel    = grant_a ? req_a_pts : req_b_pts;
          sum        = {1'b0, score_reg} + {{(SCORE_W+1-PTS_W){1'b0}}, pts_sel};
          score_next = (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];
          sr_next    = {{BCD_W{1'b0}}, score_next};
          cnt_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        if (clr) begin
          clr_pend_next = 1'b1;
        end
        sr_next  = sr_step;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_IT) begin
          seg_next        = seg_new;
          disp_valid_next = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      score_reg      <= '0;
      sr_reg         <= '0;
      cnt_reg        <= '0;
      clr_pend_reg   <= 1'b0;
      last_grant_reg <= 1'b1;
      seg_reg        <= SEG_RST;
      disp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      score_reg      <= score_next;
      sr_reg         <= sr_next;
      cnt_reg        <= cnt_next;
      clr_pend_reg   <= clr_pend_next;
      last_grant_reg <= last_grant_next;
      seg_reg        <= seg_next;
      disp_valid_reg <= disp_valid_next;
    end
  end

  // Ready is combinational from the grant; held low while reset is asserted.
  assign req_a_ready = grant_a && resetn;
  assign req_b_ready = grant_b && resetn;
  assign score       = score_reg;
  assign seg_out     = seg_reg;
  assign busy        = (state_reg == CONV);
  assign disp_valid  = disp_valid_reg;

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        a_v = 1'b0, b_v = 1'b0, clr = 1'b0;
  logic [3:0]  a_p = '0, b_p = '0;
  logic        a_rdy, b_rdy, busy, disp_valid;
  logic [9:0]  score;
  logic [20:0] seg_out;

  score_display_ctrl dut (
    .clock(clock), .resetn(resetn),
    .req_a_valid(a_v), .req_a_pts(a_p), .req_a_ready(a_rdy),
    .req_b_valid(b_v), .req_b_pts(b_p), .req_b_ready(b_rdy),
    .clr(clr), .score(score), .seg_out(seg_out),
    .busy(busy), .disp_valid(disp_valid)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] LUT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};
  localparam logic [6:0] BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_score = 0;
  bit m_last  = 1'b1;  // 1: B won the previous tie
  bit m_pend  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [20:0] model_seg(input int s);
    int h, t, o;
    logic [6:0] dh, dt, d0;
    h  = s / 100;
    t  = (s / 10) % 10;
    o  = s % 10;
    dh = LUT[h];
    dt = LUT[t];
    d0 = LUT[o];
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 0) dh = BL;
    if (h == 0 && t == 0) dt = BL;
`endif
    return {dh, dt, d0};
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_last  = 1'b1;
    m_pend  = 1'b0;
  endtask

  // Reset; returns just after a rising edge with inputs idle.
  task automatic do_reset();
    a_v = 0; b_v = 0; clr = 0;
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_score", score, 0);
    chk("rst_seg", seg_out, {LZ, LZ, LUT[0]});
    chk("rst_busy", busy, 0);
    chk("rst_dv", disp_valid, 0);
    chk("rst_ready", {a_rdy, b_rdy}, 0);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  // One idle-cycle decision plus the full conversion that follows. Inputs are
  // set by the caller; the granted requester's valid and the clear are dropped
  // after acceptance. clr_at >= 1 pulses clr during that conversion cycle.
  task automatic serve(input int clr_at, output logic ga, output logic gb,
                       output logic [9:0] sc, output logic [20:0] sg);
    int exp_g, cyc, sum;
    logic [20:0] seg_before;
    @(negedge clock);
    if (clr || m_pend) begin
      exp_g = 0; m_score = 0; m_pend = 0;
    end else begin
      if (a_v && b_v) exp_g = m_last ? 1 : 2;
      else if (a_v)   exp_g = 1;
      else            exp_g = 2;
      if (a_v && b_v) m_last = (exp_g == 2);
      sum = m_score + ((exp_g == 1) ? int'(a_p) : int'(b_p));
      m_score = (sum > 999) ? 999 : sum;
    end
    chk("idle_busy", busy, 0);
    chk("ready_a", a_rdy, exp_g == 1);
    chk("ready_b", b_rdy, exp_g == 2);
    ga = a_rdy; gb = b_rdy;
    seg_before = seg_out;
    @(posedge clock);
    #1;
    if (exp_g == 1) a_v = 0;
    if (exp_g == 2) b_v = 0;
    clr = 0;
    chk("accept_busy", busy, 1);
    chk("accept_score", score, m_score);
    cyc = 21;
    for (int c = 1; c <= 20; c++) begin
      if (c == clr_at) begin clr = 1; m_pend = 1; end
      @(posedge clock);
      #1;
      clr = 0;
      if (disp_valid) begin cyc = c; break; end
      chk("conv_busy", busy, 1);
      chk("conv_seg_hold", seg_out, seg_before);
      chk("conv_ready", {a_rdy, b_rdy}, 0);
    end
    chk("conv_latency", cyc, 10);
    chk("done_busy", busy, 0);
    chk("done_score", score, m_score);
    chk("done_seg", seg_out, model_seg(m_score));
    sc = score; sg = seg_out;
    $display("[TB] xact grant=%0d score=%0d seg=%b", exp_g, score, seg_out);
  endtask

  typedef struct {
    logic        av; logic [3:0] ap;
    logic        bv; logic [3:0] bp;
    logic        c;
    logic        ega; logic egb;
    logic [9:0]  esc;
    logic [20:0] eseg;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic ga, gb;
    logic [9:0] sc;
    logic [20:0] sg;

    vt[0] = '{1'b1, 4'd5,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 10'd5,  {LZ, LZ, LUT[5]}};
    vt[1] = '{1'b0, 4'd0,  1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 10'd14, {LZ, LUT[1], LUT[4]}};
    vt[2] = '{1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 10'd14, {LZ, LUT[1], LUT[4]}};
    vt[3] = '{1'b1, 4'd7,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'd0,  {LZ, LZ, LUT[0]}};
    vt[4] = '{1'b1, 4'd7,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 10'd7,  {LZ, LZ, LUT[7]}};
    vt[5] = '{1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 10'd22, {LZ, LUT[2], LUT[2]}};
    vt[6] = '{1'b1, 4'd15, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 10'd37, {LZ, LUT[3], LUT[7]}};
    vt[7] = '{1'b0, 4'd0,  1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 10'd42, {LZ, LUT[4], LUT[2]}};
    vt[8] = '{1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'd0,  {LZ, LZ, LUT[0]}};

    do_reset();

    // Table-driven single requests and clears
    for (int i = 0; i < 9; i++) begin
      a_v = vt[i].av; a_p = vt[i].ap;
      b_v = vt[i].bv; b_p = vt[i].bp;
      clr = vt[i].c;
      serve(-1, ga, gb, sc, sg);
      chk("tbl_ga", ga, vt[i].ega);
      chk("tbl_gb", gb, vt[i].egb);
      chk("tbl_score", sc, vt[i].esc);
      chk("tbl_seg", sg, vt[i].eseg);
    end
    a_v = 0; b_v = 0;

    // Tie arbitration from reset
    do_reset();
    a_v = 1; a_p = 3; b_v = 1; b_p = 7;
    serve(-1, ga, gb, sc, sg);
    chk("tie1_a", ga, 1);
    chk("tie1_score", sc, 3);
    chk("tie1_seg", sg, {LZ, LZ, LUT[3]});
    serve(-1, ga, gb, sc, sg);
    chk("tie1_b", gb, 1);
    chk("tie1b_score", sc, 10);
    chk("tie1b_seg", sg, {LZ, LUT[1], LUT[0]});
    a_v = 1; a_p = 1; b_v = 1; b_p = 2;
    serve(-1, ga, gb, sc, sg);
    chk("tie2_b", gb, 1);
    chk("tie2_score", sc, 12);
    serve(-1, ga, gb, sc, sg);
    chk("tie2_a", ga, 1);
    chk("tie2a_score", sc, 13);

    // Clear arriving mid-conversion with B waiting (last tie went to B)
    a_v = 1; a_p = 4; b_v = 1; b_p = 6;
    serve(4, ga, gb, sc, sg);
    chk("clrc_a", ga, 1);
    chk("clrc_score", sc, 17);
    serve(-1, ga, gb, sc, sg);
    chk("clrc_nogrant", {ga, gb}, 0);
    chk("clrc_zero", sc, 0);
    chk("clrc_seg", sg, {LZ, LZ, LUT[0]});
    serve(-1, ga, gb, sc, sg);
    chk("clrc_b", gb, 1);
    chk("clrc_bscore", sc, 6);

    // Saturation: climb to 995, then past the ceiling
    clr = 1;
    serve(-1, ga, gb, sc, sg);
    for (int i = 0; i < 66; i++) begin
      a_v = 1; a_p = 15;
      serve(-1, ga, gb, sc, sg);
    end
    a_v = 1; a_p = 5;
    serve(-1, ga, gb, sc, sg);
    chk("sat_995", sc, 995);
    a_v = 1; a_p = 9;
    serve(-1, ga, gb, sc, sg);
    chk("sat_999", sc, 999);
    chk("sat_seg", sg, {LUT[9], LUT[9], LUT[9]});
    a_v = 1; a_p = 9;
    serve(-1, ga, gb, sc, sg);
    chk("sat_hold", sc, 999);

    // Reset in the middle of a conversion
    @(negedge clock);
    a_v = 1; a_p = 3;
    @(posedge clock);
    #1;
    a_v = 0;
    repeat (4) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    chk("mrst_score", score, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_seg", seg_out, {LZ, LZ, LUT[0]});
    chk("mrst_dv", disp_valid, 0);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      #1;
      chk("mrst_quiet", {busy, disp_valid}, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      int clr_at;
      if (!a_v && $urandom_range(0, 2) != 0) begin a_v = 1; a_p = 4'($urandom_range(0, 15)); end
      if (!b_v && $urandom_range(0, 2) != 0) begin b_v = 1; b_p = 4'($urandom_range(0, 15)); end
      clr = ($urandom_range(0, 39) == 0);
      if (!a_v && !b_v && !clr && !m_pend) begin a_v = 1; a_p = 4'($urandom_range(0, 15)); end
      clr_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 10)) : -1;
      serve(clr_at, ga, gb, sc, sg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
